// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - frame-level ARP/UDP arbiter with length limit and inter-frame gap
module mac_tx_arbiter #(
    parameter int MAX_LEN    = 1514,
    parameter int IFG_CYCLES = 12
) (
    input  logic       logic_clk,
    input  logic       logic_rst,
    input  logic [7:0] arp_tdata_in,
    input  logic       arp_tvalid_in,
    input  logic       arp_tlast_in,
    output logic       arp_tready_out,
    input  logic [7:0] udp_tdata_in,
    input  logic       udp_tvalid_in,
    input  logic       udp_tlast_in,
    output logic       udp_tready_out,
    output logic [7:0] mac_tdata_out,
    output logic       mac_tvalid_out,
    output logic       mac_tlast_out,
    input  logic       mac_tready_in,
    output logic       frame_err_out,
    output logic       tx_busy_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Beat index of the last byte allowed through, and the gap counter start value.
    localparam logic [15:0] LAST_BEAT = 16'(MAX_LEN - 1);
    localparam logic [15:0] GAP_LOAD  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
    // Where a frame goes once its source tlast has been consumed.
    localparam state_t      END_STATE = (IFG_CYCLES > 0) ? GAP : IDLE;

    state_t      state;
    logic        grant;       // 0 = ARP, 1 = UDP
    logic        last_grant;  // source that completed the most recent frame
    logic [15:0] beat_cnt;
    logic [15:0] gap_cnt;

    logic [7:0]  sel_tdata;
    logic        sel_tvalid;
    logic        sel_tlast;
    logic        at_max;
    logic        out_hs;
    logic        drop_hs;

    // Select the granted source's stream.
    always_comb begin
        sel_tdata  = grant ? udp_tdata_in  : arp_tdata_in;
        sel_tvalid = grant ? udp_tvalid_in : arp_tvalid_in;
        sel_tlast  = grant ? udp_tlast_in  : arp_tlast_in;
        at_max     = (beat_cnt == LAST_BEAT);
        out_hs     = (state == XFER) && sel_tvalid && mac_tready_in;
        drop_hs    = (state == DROP) && sel_tvalid;
    end

    // Drive the output stream and the per-source ready lines from the current state.
    always_comb begin
        arp_tready_out = 1'b0;
        udp_tready_out = 1'b0;
        mac_tdata_out  = 8'h00;
        mac_tvalid_out = 1'b0;
        mac_tlast_out  = 1'b0;
        case (state)
            XFER: begin
                mac_tdata_out  = sel_tdata;
                mac_tvalid_out = sel_tvalid;
                mac_tlast_out  = sel_tlast | at_max;
                if (grant) begin
                    udp_tready_out = mac_tready_in;
                end else begin
                    arp_tready_out = mac_tready_in;
                end
            end
            DROP: begin
                if (grant) begin
                    udp_tready_out = 1'b1;
                end else begin
                    arp_tready_out = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Frame sequencer: arbitration, beat counting, truncation, and idle gap.
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            beat_cnt      <= 16'd0;
            gap_cnt       <= 16'd0;
            frame_err_out <= 1'b0;
            tx_busy_out   <= 1'b0;
        end else begin
            frame_err_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (arp_tvalid_in || udp_tvalid_in) begin
                        // On a tie the source not served last wins; otherwise the only requester.
                        grant       <= (arp_tvalid_in && udp_tvalid_in) ? ~last_grant : udp_tvalid_in;
                        beat_cnt    <= 16'd0;
                        state       <= XFER;
                        tx_busy_out <= 1'b1;
                    end
                end
                XFER: begin
                    if (out_hs) begin
                        beat_cnt <= beat_cnt + 16'd1;
                        if (sel_tlast) begin
                            last_grant  <= grant;
                            gap_cnt     <= GAP_LOAD;
                            state       <= END_STATE;
                            tx_busy_out <= (END_STATE != IDLE);
                        end else if (at_max) begin
                            // Forced tlast just went out; swallow the remainder of the frame.
                            frame_err_out <= 1'b1;
                            state         <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (drop_hs && sel_tlast) begin
                        last_grant  <= grant;
                        gap_cnt     <= GAP_LOAD;
                        state       <= END_STATE;
                        tx_busy_out <= (END_STATE != IDLE);
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) begin
                        state       <= IDLE;
                        tx_busy_out <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - directed and randomized bench for mac_tx_arbiter against a frame-level model
module tb_mac_tx_arbiter;

    localparam int MAX_LEN = 100;
    localparam int IFG     = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] arp_tdata_in;
    logic       arp_tvalid_in;
    logic       arp_tlast_in;
    logic       arp_tready_out;
    logic [7:0] udp_tdata_in;
    logic       udp_tvalid_in;
    logic       udp_tlast_in;
    logic       udp_tready_out;
    logic [7:0] mac_tdata_out;
    logic       mac_tvalid_out;
    logic       mac_tlast_out;
    logic       mac_tready_in;
    logic       frame_err_out;
    logic       tx_busy_out;

    mac_tx_arbiter #(.MAX_LEN(MAX_LEN), .IFG_CYCLES(IFG)) dut (
        .logic_clk      (clk),
        .logic_rst      (rst),
        .arp_tdata_in   (arp_tdata_in),
        .arp_tvalid_in  (arp_tvalid_in),
        .arp_tlast_in   (arp_tlast_in),
        .arp_tready_out (arp_tready_out),
        .udp_tdata_in   (udp_tdata_in),
        .udp_tvalid_in  (udp_tvalid_in),
        .udp_tlast_in   (udp_tlast_in),
        .udp_tready_out (udp_tready_out),
        .mac_tdata_out  (mac_tdata_out),
        .mac_tvalid_out (mac_tvalid_out),
        .mac_tlast_out  (mac_tlast_out),
        .mac_tready_in  (mac_tready_in),
        .frame_err_out  (frame_err_out),
        .tx_busy_out    (tx_busy_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Source byte queues (data + tlast), expected output frames, captured output frame.
    logic [7:0] arp_q[$];
    logic [7:0] udp_q[$];
    bit         arp_lq[$];
    bit         udp_lq[$];
    bit         arp_mid, udp_mid, bubbles;
    int         ready_mode;
    int         exp_len[$];
    logic [7:0] exp_d[$];
    logic [7:0] cur[$];

    int cyc, last_end, gap_last, gap_min, err_cnt, err_wide, busy_cnt, frames_done, both_rdy, bp_bad;
    bit have_end, err_prev, bp_chk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int src, input int f, input int i);
        return 8'(i + f * 16 + src * 128);
    endfunction

    task automatic add_frame(input int src, input int f, input int len);
        for (int i = 0; i < len; i++) begin
            if (src == 0) begin
                arp_q.push_back(gen(src, f, i));
                arp_lq.push_back(i == len - 1);
            end else begin
                udp_q.push_back(gen(src, f, i));
                udp_lq.push_back(i == len - 1);
            end
        end
    endtask

    // Expected output: the frame cut to MAX_LEN bytes.
    task automatic add_exp(input int src, input int f, input int len);
        int l;
        l = (len > MAX_LEN) ? MAX_LEN : len;
        exp_len.push_back(l);
        for (int i = 0; i < l; i++) exp_d.push_back(gen(src, f, i));
    endtask

    task automatic drive();
        arp_tvalid_in = (arp_q.size() > 0) && !(bubbles && arp_mid && ($urandom_range(0, 3) == 0));
        arp_tdata_in  = (arp_q.size() > 0) ? arp_q[0] : 8'h00;
        arp_tlast_in  = (arp_q.size() > 0) ? arp_lq[0] : 1'b0;
        udp_tvalid_in = (udp_q.size() > 0) && !(bubbles && udp_mid && ($urandom_range(0, 3) == 0));
        udp_tdata_in  = (udp_q.size() > 0) ? udp_q[0] : 8'h00;
        udp_tlast_in  = (udp_q.size() > 0) ? udp_lq[0] : 1'b0;
        case (ready_mode)
            0:       mac_tready_in = 1'b1;
            1:       mac_tready_in = !mac_tready_in;
            default: mac_tready_in = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic check_frame();
        int  l;
        bit  ok;
        logic [7:0] e;
        if (exp_len.size() == 0) begin
            chk("unexpected_frame", cur.size(), 0);
        end else begin
            l  = exp_len.pop_front();
            ok = 1'b1;
            chk("frame_len", cur.size(), l);
            for (int i = 0; i < l; i++) begin
                e = exp_d.pop_front();
                if (i >= cur.size() || cur[i] !== e) ok = 1'b0;
            end
            chk("frame_data", ok, 1);
        end
        cur.delete();
    endtask

    task automatic monitor();
        if (bp_chk && frames_done == 0) begin
            if (arp_tready_out !== 1'b0) bp_bad++;
            if (tx_busy_out && (udp_tready_out !== mac_tready_in)) bp_bad++;
        end
        if (arp_tready_out && udp_tready_out) both_rdy++;
        if (mac_tvalid_out && mac_tready_in) begin
            if (cur.size() == 0 && have_end) begin
                gap_last = cyc - last_end;
                if (gap_last < gap_min) gap_min = gap_last;
            end
            cur.push_back(mac_tdata_out);
            if (mac_tlast_out) begin
                check_frame();
                last_end = cyc;
                have_end = 1'b1;
                frames_done++;
            end
        end
        if (frame_err_out) begin
            err_cnt++;
            if (err_prev) err_wide++;
        end
        err_prev = frame_err_out;
        if (tx_busy_out) busy_cnt++;
    endtask

    // One clock: sample at negedge, then advance sources and drive just after posedge.
    task automatic step();
        bit ahs, uhs;
        @(negedge clk);
        ahs = arp_tvalid_in && arp_tready_out;
        uhs = udp_tvalid_in && udp_tready_out;
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (ahs) begin
            arp_mid = !arp_lq[0];
            void'(arp_q.pop_front());
            void'(arp_lq.pop_front());
        end
        if (uhs) begin
            udp_mid = !udp_lq[0];
            void'(udp_q.pop_front());
            void'(udp_lq.pop_front());
        end
        drive();
    endtask

    task automatic clear_state();
        arp_q.delete(); arp_lq.delete(); udp_q.delete(); udp_lq.delete();
        exp_len.delete(); exp_d.delete(); cur.delete();
        arp_mid = 0; udp_mid = 0; bubbles = 0; ready_mode = 0; bp_chk = 0;
        have_end = 0; err_prev = 0; gap_min = 1000000; gap_last = 0;
        err_cnt = 0; err_wide = 0; busy_cnt = 0; frames_done = 0; both_rdy = 0; bp_bad = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_state();
        drive();
    endtask

    task automatic run_done(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(arp_q.size() == 0 && udp_q.size() == 0 && !tx_busy_out) && n < budget);
        chk("run_in_budget", n < budget, 1);
        chk("no_missing_frames", exp_len.size(), 0);
        chk("no_partial_frame", cur.size(), 0);
    endtask

    initial begin
        int n, na, nu, nerr, len;
        rst = 1'b1;
        clear_state();
        mac_tready_in = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arp_tready", arp_tready_out, 0);
        chk("rst_udp_tready", udp_tready_out, 0);
        chk("rst_mac_tvalid", mac_tvalid_out, 0);
        chk("rst_mac_tlast", mac_tlast_out, 0);
        chk("rst_mac_tdata", mac_tdata_out, 8'h00);
        chk("rst_frame_err", frame_err_out, 0);
        chk("rst_tx_busy", tx_busy_out, 0);
        @(posedge clk);
        #1;

        // Single ARP frame 00..3B
        do_reset();
        add_frame(0, 0, 60);
        add_exp(0, 0, 60);
        drive();
        run_done(500);
        chk("single_err", err_cnt, 0);
        chk("single_busy_cycles", busy_cnt, 60 + IFG);

        // Simultaneous requests: ARP first, UDP exactly IFG+2 cycles after ARP's last beat
        do_reset();
        add_frame(0, 0, 64);
        add_frame(1, 0, 64);
        add_exp(0, 0, 64);
        add_exp(1, 0, 64);
        drive();
        run_done(500);
        chk("simul_frames", frames_done, 2);
        chk("simul_gap", gap_last, IFG + 2);
        chk("simul_err", err_cnt, 0);

        // Round robin, lengths around the MAX_LEN boundary (1, 100, 101, 2, ...)
        do_reset();
        add_frame(0, 0, 1);   add_frame(0, 1, 100); add_frame(0, 2, 101); add_frame(0, 3, 20);
        add_frame(1, 0, 64);  add_frame(1, 1, 99);  add_frame(1, 2, 2);   add_frame(1, 3, 100);
        add_exp(0, 0, 1);   add_exp(1, 0, 64);
        add_exp(0, 1, 100); add_exp(1, 1, 99);
        add_exp(0, 2, 101); add_exp(1, 2, 2);
        add_exp(0, 3, 20);  add_exp(1, 3, 100);
        drive();
        run_done(3000);
        chk("rr_frames", frames_done, 8);
        chk("rr_err", err_cnt, 1);
        chk("rr_err_width", err_wide, 0);

        // Backpressure on a UDP frame while ARP waits
        do_reset();
        ready_mode = 1;
        add_frame(1, 0, 60);
        add_exp(1, 0, 60);
        drive();
        step();
        step();
        add_frame(0, 0, 10);
        add_exp(0, 0, 10);
        bp_chk = 1'b1;
        drive();
        run_done(1000);
        chk("bp_ready_rules", bp_bad, 0);
        chk("bp_frames", frames_done, 2);
        chk("bp_both_ready", both_rdy, 0);

        // Oversize UDP frame
        do_reset();
        add_frame(1, 0, 150);
        add_exp(1, 0, 150);
        drive();
        run_done(1000);
        chk("over_err", err_cnt, 1);
        chk("over_err_width", err_wide, 0);
        chk("over_frames", frames_done, 1);
        chk("over_busy_cycles", busy_cnt, MAX_LEN + 50 + IFG);

        // Reset at byte 20 of an ARP frame, then a clean UDP frame
        do_reset();
        add_frame(0, 0, 60);
        drive();
        n = 0;
        while (cur.size() < 20 && n < 200) begin
            step();
            n++;
        end
        chk("mid_reach_byte20", cur.size(), 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        arp_q.delete(); arp_lq.delete(); arp_mid = 0;
        drive();
        @(negedge clk);
        chk("mid_rst_arp_tready", arp_tready_out, 0);
        chk("mid_rst_mac_tvalid", mac_tvalid_out, 0);
        chk("mid_rst_mac_tlast", mac_tlast_out, 0);
        chk("mid_rst_mac_tdata", mac_tdata_out, 8'h00);
        chk("mid_rst_frame_err", frame_err_out, 0);
        chk("mid_rst_tx_busy", tx_busy_out, 0);
        @(posedge clk);
        #1;
        cur.delete(); exp_len.delete(); exp_d.delete(); have_end = 0; frames_done = 0;
        add_frame(1, 0, 30);
        add_exp(1, 0, 30);
        drive();
        run_done(500);
        chk("mid_after_frames", frames_done, 1);

        // Randomized: source bubbles, random ready, random lengths; strict alternation while both queued
        do_reset();
        bubbles = 1'b1;
        ready_mode = 2;
        na = $urandom_range(2, 6);
        nu = $urandom_range(2, 6);
        nerr = 0;
        for (int f = 0; f < 6; f++) begin
            if (f < na) begin
                len = $urandom_range(1, 130);
                add_frame(0, f, len);
                add_exp(0, f, len);
                if (len > MAX_LEN) nerr++;
            end
            if (f < nu) begin
                len = $urandom_range(1, 130);
                add_frame(1, f, len);
                add_exp(1, f, len);
                if (len > MAX_LEN) nerr++;
            end
        end
        drive();
        run_done(20000);
        chk("rand_frames", frames_done, na + nu);
        chk("rand_err", err_cnt, nerr);
        chk("rand_err_width", err_wide, 0);
        chk("rand_both_ready", both_rdy, 0);
        chk("rand_gap_min_ok", gap_min >= IFG + 2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Frame-level arbiter and sequencer in front of `mac_tx_crc_calculate`. It shares the single MAC TX byte stream between two frame sources: ARP and UDP/IP. Each grant lasts for a whole frame. The block enforces a maximum frame length, with truncation and an error pulse, and inserts a programmable idle gap between frames. It runs entirely in the `logic_clk` domain; the CRC block handles the crossing to `phy_tx_clk`.

## Interface
- `MAX_LEN`, 1514: maximum accepted bytes per frame, excluding FCS. Legal range is 2..65535.
- `IFG_CYCLES`, 12: idle `logic_clk` cycles forced after each frame ends. 0 means no gap.
- `logic_clk` in 1: single clock.
- `logic_rst` in 1: synchronous, active-high reset.
- `arp_tdata_in` in 8: ARP source byte.
- `arp_tvalid_in` in 1: ARP byte valid.
- `arp_tlast_in` in 1: last byte of the ARP frame.
- `arp_tready_out` out 1: ARP byte accepted.
- `udp_tdata_in` in 8: UDP source byte.
- `udp_tvalid_in` in 1: UDP byte valid.
- `udp_tlast_in` in 1: last byte of the UDP frame.
- `udp_tready_out` out 1: UDP byte accepted.
- `mac_tdata_out` out 8: byte to the CRC block.
- `mac_tvalid_out` out 1: byte valid.
- `mac_tlast_out` out 1: last byte of the frame.
- `mac_tready_in` in 1: CRC block ready.
- `frame_err_out` out 1: one-cycle pulse when a frame is truncated.
- `tx_busy_out` out 1: high in every state except IDLE.

## Operation
- A handshake occurs on a channel when both valid and ready are high on a rising edge of `logic_clk`.
- The FSM has four states: IDLE, XFER, DROP, GAP. Grant is a registered index; 0 means ARP, 1 means UDP.
- **IDLE**
  - Outputs are quiet: all tready = 0, `mac_tvalid_out` = 0.
  - If either source tvalid is high, latch the grant and go to XFER on the next cycle.
  - Both sources valid: grant the source not served last. The pointer `last_grant` resets to 1, so ARP wins the first tie.
  - One source valid: grant it.
- **XFER** (combinational mux from the granted source)
  - `mac_tdata_out` and `mac_tvalid_out` follow the granted source.
  - The granted tready equals `mac_tready_in`; the other tready is 0.
  - `mac_tlast_out` = granted tlast OR (`beat_cnt` == `MAX_LEN`-1).
  - `beat_cnt` is 16 bits, cleared on entry to XFER, and increments on each output handshake.
- **Leaving XFER**
  - Handshake with source tlast = 1: set `last_grant` to the granted source, then go to GAP. If `IFG_CYCLES` = 0, go to IDLE instead.
  - Handshake on the `MAX_LEN`-th beat without source tlast: forced tlast goes out on that beat. `frame_err_out` pulses on the next cycle. Go to DROP.
  - Handshake on the `MAX_LEN`-th beat with source tlast = 1: normal end, no error.
- **DROP**
  - `mac_tvalid_out` = 0. Granted tready = 1, so the rest of the frame is discarded.
  - On a granted-source handshake with tlast: update `last_grant`, then go to GAP, or to IDLE if `IFG_CYCLES` = 0.
- **GAP**
  - All tready = 0 and `mac_tvalid_out` = 0.
  - A counter loads `IFG_CYCLES`-1 on entry and decrements; at 0, go to IDLE.
- Source tvalid must not drop mid-frame except between beats. A source bubble stalls the output, which is legal because the CRC block tolerates `mac_tvalid` gaps.
- **Reset** (including mid-frame)
  - Next state is IDLE; `beat_cnt`, gap counter and `frame_err_out` clear; `last_grant` = 1.
  - Any partial frame is abandoned without a forced tlast.

## Timing
- Reset values:
  - `arp_tready_out` = 0 and `udp_tready_out` = 0.
  - `mac_tvalid_out` = 0, `mac_tlast_out` = 0, `mac_tdata_out` = 8'h00.
  - `frame_err_out` = 0 and `tx_busy_out` = 0.
- Arbitration latency: tvalid seen high in IDLE at cycle N gives the grant at N+1. The first byte can be accepted at N+1.
- Data path through XFER has zero added latency; it is combinational.
- Back-to-back frames: the last beat handshakes at cycle T. The next frame's first possible handshake is at T+`IFG_CYCLES`+2 (gap cycles, plus one IDLE cycle, plus the grant cycle).
- `frame_err_out` is registered and high for exactly one cycle, the cycle after the truncating beat.
- `tx_busy_out` is registered from the state and is high in XFER, DROP and GAP.

## Test plan
- **Single ARP frame.** ARP sends 60 bytes 00..3B with tlast on 3B, `mac_tready_in` = 1.
  - The output shows the same 60 bytes, tlast on byte 60, no error.
  - `tx_busy_out` stays high 60+12 cycles.
- **Simultaneous requests after reset.** Both sources assert valid in the same cycle, 64-byte frames each.
  - ARP frame goes out first, then 12 idle cycles.
  - UDP frame follows, first byte exactly 14 cycles after ARP's last beat.
- **Round-robin fairness.** Both sources stream 4 frames each continuously.
  - Output order is ARP, UDP, ARP, UDP, ARP, UDP, ARP, UDP.
- **Backpressure.** `mac_tready_in` toggles 1/0 every cycle during a 60-byte UDP frame.
  - `udp_tready_out` mirrors `mac_tready_in`; no bytes are lost or duplicated.
  - `arp_tready_out` stays 0 even while ARP is valid.
- **Oversize frame.** With `MAX_LEN` = 100, UDP sends 150 bytes.
  - 100 bytes are output, tlast forced on byte 100, `frame_err_out` pulses once.
  - Bytes 101..150 are accepted with `mac_tvalid_out` = 0, then the gap follows.
- **Reset mid-frame.** `logic_rst` pulses for 1 cycle at byte 20 of an ARP frame.
  - Next cycle all outputs are at reset values.
  - A new UDP frame afterwards transmits cleanly from its byte 0.
